// File: rtl/mxn_pipe.sv
// -----------------------------------------------------------------------------
// mxn_pipe
//   NCH-input, WIDTH-bit multiplexer with a single registered output stage and
//   valid/ready handshakes on every channel. The channel is chosen either
//   directly from cmd (fixed mode) or by round-robin arbitration among the
//   channels currently presenting valid data.
//
// Ports
//   ck       clock, rising edge
//   nrst     asynchronous active-low reset
//   mode     0 = fixed select from cmd, 1 = round-robin
//   cmd      channel select in fixed mode
//   i        channel data, channel k at [k*WIDTH +: WIDTH]
//   i_valid  per-channel valid
//   i_ready  per-channel ready (combinational, zero while in reset)
//   q        registered output data
//   q_ch     index of the channel that produced q
//   q_valid  output valid
//   q_ready  downstream ready
// -----------------------------------------------------------------------------
module mxn_pipe #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 ck,
  input  logic                 nrst,
  input  logic                 mode,
  input  logic [SELW-1:0]      cmd,
  input  logic [NCH*WIDTH-1:0] i,
  input  logic [NCH-1:0]       i_valid,
  output logic [NCH-1:0]       i_ready,
  output logic [WIDTH-1:0]     q,
  output logic [SELW-1:0]      q_ch,
  output logic                 q_valid,
  input  logic                 q_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             valid_q, valid_d;

  logic             slot_ok;   // a channel is selected this cycle
  logic [SELW-1:0]  slot_idx;  // the selected channel
  logic [SELW-1:0]  cand;
  logic             stage_ready;
  logic             in_xfer;

  // Channel selection. In fixed mode the slot exists whenever cmd names a real
  // channel, even if that channel is idle, so i_ready[cmd] can be offered
  // ahead of i_valid. In round-robin mode only a valid channel can be chosen.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    slot_ok  = 1'b0;
    slot_idx = '0;
    cand     = '0;
    if (!mode) begin
      slot_idx = cmd;
      slot_ok  = (int'(cmd) < NCH);
    end else begin
      // Scan from the farthest offset down to zero so the channel nearest to
      // the pointer is the last one written and therefore wins.
      for (int off = NCH - 1; off >= 0; off--) begin
        cand = SELW'((int'(ptr_q) + off) % NCH);
        if (i_valid[cand]) begin
          slot_ok  = 1'b1;
          slot_idx = cand;
        end
      end
    end
  end

  assign stage_ready = ~valid_q | q_ready;
  assign in_xfer     = nrst & slot_ok & stage_ready & i_valid[slot_idx];

  always_comb begin
    i_ready = '0;
    if (nrst && slot_ok) i_ready[slot_idx] = stage_ready;
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (in_xfer) begin
      data_d  = i[int'(slot_idx)*WIDTH +: WIDTH];
      ch_d    = slot_idx;
      valid_d = 1'b1;
      if (mode) ptr_d = (slot_idx == SELW'(NCH - 1)) ? '0 : slot_idx + 1'b1;
    end else if (valid_q && q_ready) begin
      // Drained with nothing behind it: data and channel keep their last value.
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign q       = data_q;
  assign q_ch    = ch_q;
  assign q_valid = valid_q;

endmodule

// File: doc/mxn_pipe.md
Name: mxn_pipe

Overview:
- Parametrised successor to the 2:1 mux cell: an NCH-input, WIDTH-bit multiplexer with one registered output stage and valid/ready handshakes on every channel.
- Two selection modes: fixed select from cmd, or round-robin arbitration among valid channels.
- Sits in datapath glue wherever several producers share one consumer, replacing chains of mx2 cells plus a separate flop stage.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- NCH, 4, number of input channels (2..16).
- SELW, 2, select/channel-index width; must equal ceil(log2(NCH)).

Ports:
- ck  input  1  clock; all state updates on its rising edge.
- nrst  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select from cmd; 1 = round-robin.
- cmd  input  SELW  channel select in fixed mode; ignored in round-robin mode.
- i  input  NCH*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- i_valid  input  NCH  per-channel valid.
- i_ready  output  NCH  per-channel ready; combinational.
- q  output  WIDTH  registered output data.
- q_ch  output  SELW  index of the channel that produced q.
- q_valid  output  1  output valid.
- q_ready  input  1  downstream ready.

Behaviour:
- Reset (nrst low, asynchronous): q=0, q_ch=0, q_valid=0, round-robin pointer ptr=0. i_ready is all-zero while nrst is low. Release is taken synchronously at the next ck edge.
- Stage readiness: stage_ready = ~q_valid | q_ready.
- Grant, fixed mode:
  - g = cmd.
  - Grant exists iff cmd < NCH and i_valid[cmd]=1.
  - i_ready[cmd] = stage_ready when cmd < NCH; all other i_ready bits are 0.
  - If cmd >= NCH, all i_ready bits are 0 and no transfer occurs.
- Grant, round-robin mode:
  - g = first k in order ptr, ptr+1, …, NCH-1, 0, …, ptr-1 with i_valid[k]=1.
  - i_ready[g] = stage_ready; all other i_ready bits are 0.
  - No valid channel means no grant and i_ready is all-zero.
  - i_ready depends combinationally on i_valid in this mode. This is permitted; upstream must not make i_valid depend on i_ready.
- Input transfer: i_valid[g] & i_ready[g] at the ck edge. Then q <= channel g data, q_ch <= g, q_valid <= 1.
- Output transfer: q_valid & q_ready.
  - If an output transfer happens with no input transfer in the same cycle, q_valid <= 0. q and q_ch hold their last values.
- Simultaneous output and input transfer: new data loads and q_valid stays 1. This gives full throughput of one word per cycle.
- q_valid=1 & q_ready=0: q, q_ch and q_valid hold; all i_ready bits are 0.
- Latency: one cycle from input transfer to q_valid.
- Pointer:
  - Updates only on an input transfer in round-robin mode: ptr <= (g+1) mod NCH, with wrap from NCH-1 to 0.
  - Held in fixed mode and across mode changes.
- Mode or cmd change: affects only the combinational grant. A word already in the register is unaffected; the change takes effect in the same cycle it is applied.
- Channel data is never lost or duplicated. A channel holding i_valid=1 without i_ready keeps its data.

Test Plan:
- Reset: drive nrst=0 mid-stream with q_valid=1, q=8'hA5 -> q=0, q_ch=0, q_valid=0 immediately (no clock edge); i_ready=4'b0000.
- Fixed mode, cmd=2, i_valid=4'b1111, ch2 data=8'h3C, q_ready=1 -> i_ready=4'b0100; next cycle q=8'h3C, q_ch=2, q_valid=1.
- Fixed mode, cmd=2, i_valid=4'b1011 -> no transfer, i_ready=4'b0100, q_valid falls to 0 after the pending word drains.
- Round-robin, all channels valid, q_ready=1 for 8 cycles -> q_ch sequence 0,1,2,3,0,1,2,3, one word per cycle. Pointer wrap from 3 to 0 is checked.
- Round-robin, i_valid=4'b1001, ptr=1 -> grant ch3, then ch0, then ch3.
- Backpressure: q_valid=1, q_ready=0 for 3 cycles -> q, q_ch stable, i_ready=0. When q_ready rises with ch1 valid -> ch1 loads in the same cycle and q_valid stays 1.
- Mode switch with ptr=2 going fixed -> round-robin -> ptr is still 2, and the first grant searches from ch2.
